// File: rtl/cache_burst_addr_gen.sv
// Rebuilds byte addresses from {tag, index, word} and sequences an 8-beat line burst (linear or critical-word-first wrap).
// Latency: first beat valid the cycle after accept; one beat per cycle while mem_ready=1; done pulses one cycle after the 8th beat.
// Backpressure: mem_ready=0 holds the current beat stable; requests are refused (req_ready=0) from accept until back in IDLE.
module cache_burst_addr_gen #(
    parameter  int ADDR_W   = 16,
    parameter  int INDEX_W  = 5,
    parameter  int OFFSET_W = 5,
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [TAG_W-1:0]    req_tag,
    input  logic [INDEX_W-1:0]  req_index,
    input  logic [2:0]          req_word,
    input  logic                req_wrap,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic                mem_last,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [TAG_W-1:0]     r_tag;
    logic [TAG_W-1:0]     w_tag_nxt;
    logic [INDEX_W-1:0]   r_index;
    logic [INDEX_W-1:0]   w_index_nxt;
    logic [2:0]           r_word_ptr;
    logic [2:0]           w_word_ptr_nxt;
    logic [2:0]           r_beat;
    logic [2:0]           w_beat_nxt;
    logic                 r_mem_valid;
    logic                 w_mem_valid_nxt;
    logic                 r_mem_last;
    logic                 w_mem_last_nxt;
    logic                 r_busy;
    logic                 w_busy_nxt;
    logic                 r_done;
    logic                 w_done_nxt;
    logic                 w_mem_hs;

    assign w_mem_hs  = r_mem_valid && mem_ready;
    assign req_ready = (r_state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_tag       <= '0;
            r_index     <= '0;
            r_word_ptr  <= '0;
            r_beat      <= '0;
            r_mem_valid <= 1'b0;
            r_mem_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tag       <= w_tag_nxt;
            r_index     <= w_index_nxt;
            r_word_ptr  <= w_word_ptr_nxt;
            r_beat      <= w_beat_nxt;
            r_mem_valid <= w_mem_valid_nxt;
            r_mem_last  <= w_mem_last_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_tag_nxt       = r_tag;
        w_index_nxt     = r_index;
        w_word_ptr_nxt  = r_word_ptr;
        w_beat_nxt      = r_beat;
        w_mem_valid_nxt = r_mem_valid;
        w_mem_last_nxt  = r_mem_last;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;

        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_tag_nxt       = req_tag;
                    w_index_nxt     = req_index;
                    w_word_ptr_nxt  = req_wrap ? req_word : 3'd0;
                    w_beat_nxt      = 3'd0;
                    w_mem_valid_nxt = 1'b1;
                    w_mem_last_nxt  = 1'b0;
                    w_busy_nxt      = 1'b1;
                    w_state_nxt     = BURST;
                end
            end
            BURST: begin
                if (w_mem_hs) begin
                    if (r_beat == 3'd7) begin
                        w_mem_valid_nxt = 1'b0;
                        w_mem_last_nxt  = 1'b0;
                        w_done_nxt      = 1'b1;
                        w_state_nxt     = DONE;
                    end else begin
                        // 3-bit pointer wraps 7->0 inside the line; tag/index untouched
                        w_word_ptr_nxt  = r_word_ptr + 3'd1;
                        w_beat_nxt      = r_beat + 3'd1;
                        w_mem_last_nxt  = (r_beat == 3'd6);
                    end
                end
            end
            DONE: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign mem_addr  = {r_tag, r_index, r_word_ptr, 2'b00};
    assign mem_valid = r_mem_valid;
    assign mem_last  = r_mem_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_cache_burst_addr_gen.sv
// Self-checking bench for cache_burst_addr_gen: table-driven bursts, randomized bursts vs. a queue model, reset corners.
module tb_cache_burst_addr_gen;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_tag;
    logic [4:0]  req_index;
    logic [2:0]  req_word;
    logic        req_wrap;
    logic [15:0] mem_addr;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_last;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    cache_burst_addr_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_tag   (req_tag),
        .req_index (req_index),
        .req_word  (req_word),
        .req_wrap  (req_wrap),
        .mem_addr  (mem_addr),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_last  (mem_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  tag;
        logic [4:0]  idx;
        logic [2:0]  word;
        logic        wrap;
        int          stall_beat;
        int          stall_cycles;
        logic [15:0] exp_first;
        logic [15:0] exp_last;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected beat k address from the line-burst rules, independent of any state machine.
    function automatic logic [15:0] model_addr(input logic [5:0] tag, input logic [4:0] idx,
                                               input logic [2:0] w, input logic wrap, input int k);
        int word;
        word = wrap ? ((int'(w) + k) % 8) : k;
        return 16'((int'(tag) << 10) | (int'(idx) << 5) | (word << 2));
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge of the following IDLE cycle.
    // stall_beat<0 selects random mem_ready; keep_req holds req_valid high with shifting fields during the burst.
    task automatic run_burst(input logic [5:0] tag, input logic [4:0] idx, input logic [2:0] w,
                             input logic wrap, input int stall_beat, input int stall_cycles,
                             input bit keep_req,
                             output logic [15:0] first_a, output logic [15:0] last_a);
        logic [15:0] expq[$];
        int hs;
        int cyc;
        int stall_left;
        first_a = '0;
        last_a  = '0;
        for (int k = 0; k < 8; k++) expq.push_back(model_addr(tag, idx, w, wrap, k));
        check("idle_req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_tag   = tag;
        req_index = idx;
        req_word  = w;
        req_wrap  = wrap;
        mem_ready = 1'b1;
        @(negedge clk);
        check("first_valid", 32'(mem_valid), 32'd1);
        check("busy_after_accept", 32'(busy), 32'd1);
        hs = 0;
        cyc = 0;
        stall_left = stall_cycles;
        while (hs < 8 && cyc < 200) begin
            if (keep_req) begin
                req_valid = 1'b1;
                req_tag   = 6'($urandom);
                req_index = 5'($urandom);
                req_word  = 3'($urandom);
                req_wrap  = 1'($urandom);
            end else begin
                req_valid = 1'b0;
            end
            check("beat_valid", 32'(mem_valid), 32'd1);
            check("beat_addr", 32'(mem_addr), 32'(expq[hs]));
            check("beat_last", 32'(mem_last), (hs == 7) ? 32'd1 : 32'd0);
            check("beat_req_ready", 32'(req_ready), 32'd0);
            check("beat_done", 32'(done), 32'd0);
            if (hs == 0) first_a = mem_addr;
            if (hs == 7) last_a = mem_addr;
            if (stall_beat < 0)
                mem_ready = ($urandom_range(0, 3) != 0);
            else if (hs == stall_beat && stall_left > 0) begin
                mem_ready = 1'b0;
                stall_left--;
            end else
                mem_ready = 1'b1;
            @(negedge clk);
            if (mem_ready) hs++;
            cyc++;
        end
        check("handshake_count", 32'(hs), 32'd8);
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd1);
        check("done_valid", 32'(mem_valid), 32'd0);
        check("done_last", 32'(mem_last), 32'd0);
        check("done_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("idle_done_low", 32'(done), 32'd0);
        check("idle_busy_low", 32'(busy), 32'd0);
        check("idle_valid_low", 32'(mem_valid), 32'd0);
        if (!keep_req) req_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        logic [15:0] fa;
        logic [15:0] la;
        tbl[0] = '{6'h2A, 5'h13, 3'd5, 1'b1, 0,  0, 16'hAA74, 16'hAA70};
        tbl[1] = '{6'h00, 5'h00, 3'd6, 1'b0, 0,  0, 16'h0000, 16'h001C};
        tbl[2] = '{6'h00, 5'h00, 3'd6, 1'b0, 2,  3, 16'h0000, 16'h001C};
        tbl[3] = '{6'h3F, 5'h1F, 3'd7, 1'b1, 0,  0, 16'hFFFC, 16'hFFF8};
        tbl[4] = '{6'h15, 5'h0A, 3'd0, 1'b1, 5,  2, 16'h5540, 16'h555C};
        tbl[5] = '{6'h01, 5'h1F, 3'd3, 1'b1, 7,  1, 16'h07EC, 16'h07E8};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_tag   = '0;
        req_index = '0;
        req_word  = '0;
        req_wrap  = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_mem_last", 32'(mem_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_burst(tbl[i].tag, tbl[i].idx, tbl[i].word, tbl[i].wrap,
                      tbl[i].stall_beat, tbl[i].stall_cycles, 1'b0, fa, la);
            check($sformatf("tbl%0d_first", i), 32'(fa), 32'(tbl[i].exp_first));
            check($sformatf("tbl%0d_last", i), 32'(la), 32'(tbl[i].exp_last));
        end

        // Requests held during a burst are ignored; the next accept lands in the IDLE cycle after done.
        run_burst(6'h11, 5'h05, 3'd2, 1'b1, 0, 0, 1'b1, fa, la);
        check("hold_req_idle_ready", 32'(req_ready), 32'd1);
        run_burst(6'h2C, 5'h19, 3'd6, 1'b1, 0, 0, 1'b0, fa, la);
        check("b2b_first", 32'(fa), 32'hB338);
        check("b2b_last", 32'(la), 32'hB334);

        for (int r = 0; r < 20; r++) begin
            run_burst(6'($urandom), 5'($urandom), 3'($urandom), 1'($urandom), -1, 0, 1'b0, fa, la);
        end

        // Asynchronous reset while beat 4 is presented.
        req_valid = 1'b1;
        req_tag   = 6'h2A;
        req_index = 5'h13;
        req_word  = 3'd1;
        req_wrap  = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_addr", 32'(mem_addr), 32'hAA74);
        check("pre_rst_valid", 32'(mem_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(mem_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_last", 32'(mem_last), 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd1);
        check("mid_rst_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_done", 32'(done), 32'd0);
        run_burst(6'h07, 5'h02, 3'd4, 1'b0, 3, 2, 1'b0, fa, la);
        check("post_rst_first", 32'(fa), 32'h1C40);
        check("post_rst_last", 32'(la), 32'h1C5C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
